pe_array_seq: RTL and testbench
===============================

// Module: pe_array_seq
// PURPOSE
//  Sequencer for the NxN weight-stationary systolic array of PEs. Per job it clears
//  PE weights, loads one weight row per cycle, streams k_len activation vectors,
//  drains the pipeline and flags valid column results. It sits between the top-level
//  controller (start/done) and the array plus its weight, activation and skew buffers.
// PARAMETERS
//  ARRAY_SIZE  8    array rows = columns (N)
//  K_MAX       256  maximum activation vectors per job
//  KW          9    width of k_len, $clog2(K_MAX+1)
//  AW          8    buffer address width, >= $clog2(max(K_MAX,ARRAY_SIZE))
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-high reset
//  start      in   1           job request, sampled in IDLE only
//  k_len      in   KW          activation vectors in job, latched with start
//  busy       out  1           high in every state except IDLE
//  done       out  1           one-cycle pulse in DONE
//  z_weight   out  1           to all PEs, high in CLEAR only
//  wgt_rd_en  out  1           weight buffer read strobe (1-cycle read latency)
//  wgt_rd_addr out AW          weight row address
//  weight_en  out  ARRAY_SIZE  bit r loads weight row r into PE row r
//  act_rd_en  out  1           activation buffer read strobe (1-cycle latency)
//  act_rd_addr out AW          activation vector index, unskewed
//  go         out  1           to all PEs, high in STREAM and DRAIN
//  col_valid  out  ARRAY_SIZE  bit j: bottom PE of column j holds a valid result
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0. Reset mid-job aborts the job with
//   no done pulse. All outputs are registered or decoded from registered state.
//  IDLE: start=1 -> latch k_len; k_len==0 -> DONE, else -> CLEAR. start while busy ignored.
//  CLEAR (1 cycle): z_weight=1 -> LOAD_W.
//  LOAD_W (N+1 cycles, c=0..N): wgt_rd_en=1, wgt_rd_addr=c for c<N;
//   weight_en=one-hot(c-1) for c>=1, else 0. After c=N -> STREAM.
//  STREAM (k_len cycles, t=0..k_len-1): act_rd_en=1, act_rd_addr=t, go=1 -> DRAIN.
//   Downstream skew delays row i by i cycles.
//  DRAIN (2N cycles): go=1, act_rd_en=0 -> DONE.
//  DONE (1 cycle): done=1, go=0 -> IDLE. A start in DONE is ignored.
//  Timing, with S = first STREAM cycle: vector t reaches PE(i,j) at S+1+i+j.
//   col_valid[j]=1 exactly in cycles S+N+1+j+t for t=0..k_len-1.
//   The last valid result is at S+2N+k_len-1, the final DRAIN cycle.
//  Job length from the start-sample cycle to the done pulse is k_len+3N+3 cycles.
//  col_valid generation: a per-column shift chain of STREAM-phase flags, delayed
//   N+1+j cycles; the chain is cleared on rst.
//  No stall: dropping go zeroes the PE outputs and would corrupt the in-flight wavefront.
//  Counters saturate-free: phase counter width $clog2(K_MAX+2N+1); k_len > K_MAX is
//   illegal and is caught by an assertion.
// STRUCTURE
//  Shared package (define.v): state encodings ST_IDLE/CLEAR/LOAD_W/STREAM/DRAIN/DONE
//   and the ARRAY_SIZE and K_MAX defaults beside `DATA_SIZE.
//  Sub-module valid_delay_line: parameterised per-column delay of the stream flag
//   that produces col_valid. The FSM and counters stay in this module.
// TESTING (N=4)
//  1. start@0, k_len=3 -> CLEAR@1; LOAD_W 2..6; weight_en=0001@3..1000@6;
//     act_rd_addr 0,1,2 @7..9; col_valid[0] @12..14, col_valid[3] @15..17; done@18.
//  2. start@0, k_len=0 -> done@1, busy=1 only @1; go, weight_en and act_rd_en never assert.
//  3. start held high during the case-1 job -> the second job begins only after
//     return to IDLE (start sampled @19); no early restart.
//  4. rst=1 @8 during STREAM of case 1 -> @9 all outputs 0, state IDLE, no done pulse;
//     a new start runs case 1 cleanly.
//  5. k_len=K_MAX=256 -> act_rd_addr runs 0..255 without wrap; done exactly
//     k_len+3N+3 cycles after start.
//  6. Back-to-back jobs with k_len=1 then k_len=5 -> per-column col_valid pulse counts are
//     1 then 5; z_weight pulses once per job.

Source files
------------

// File: rtl/pe_array_seq_pkg.sv
// Shared definitions for the systolic-array sequencer: default array geometry,
// the sequencer state encoding and the phase-counter width helper.
package pe_array_seq_pkg;

    localparam int ARRAY_SIZE_DEF = 8;
    localparam int K_MAX_DEF      = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // The longest phase is STREAM (K_MAX cycles), and DRAIN needs 2N cycles.
    // Sizing for the sum keeps every phase count free of wrap-around.
    function automatic int cnt_width(input int n, input int kmax);
        return $clog2(kmax + 2 * n + 1);
    endfunction

endpackage

// File: rtl/pe_array_seq_if.sv
// Controller/array-side bundle of the sequencer: job handshake plus the buffer
// and PE control strobes. The sequencer uses the slave view.
interface pe_array_seq_if
    import pe_array_seq_pkg::*;
#(
    parameter int N  = ARRAY_SIZE_DEF,
    parameter int KW = $clog2(K_MAX_DEF + 1),
    parameter int AW = 8
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          z_weight;
    logic          wgt_rd_en;
    logic [AW-1:0] wgt_rd_addr;
    logic [N-1:0]  weight_en;
    logic          act_rd_en;
    logic [AW-1:0] act_rd_addr;
    logic          go;
    logic [N-1:0]  col_valid;

    modport master (
        output start, k_len,
        input  busy, done, z_weight, wgt_rd_en, wgt_rd_addr, weight_en,
               act_rd_en, act_rd_addr, go, col_valid
    );

    modport slave (
        input  start, k_len,
        output busy, done, z_weight, wgt_rd_en, wgt_rd_addr, weight_en,
               act_rd_en, act_rd_addr, go, col_valid
    );

endinterface

// File: rtl/pe_array_seq_valid_delay.sv
// Per-column delay of the STREAM-phase flag. Column j sees the flag N+1+j
// cycles late, which lines it up with the wavefront leaving the bottom PE.
module pe_array_seq_valid_delay
    import pe_array_seq_pkg::*;
#(
    parameter int N = ARRAY_SIZE_DEF
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flag,
    output logic [N-1:0] o_col_valid
);

    // r_chain[d-1] holds the flag delayed by d cycles
    logic [2*N-1:0] r_chain;

    // shift the stream flag along one chain; cleared so an aborted job leaves no stale valids
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[2*N-2:0], i_flag};
        end
    end

    assign o_col_valid = r_chain[2*N-1:N];

endmodule

// File: rtl/pe_array_seq.sv
// Job sequencer for the NxN weight-stationary array: clear weights, load one
// weight row per cycle, stream k_len activation vectors, drain, pulse done.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | waiting for start; k_len latched with start
//  CLEAR     | one cycle of z_weight to zero all PE weights
//  LOAD_W    | N+1 cycles: read row c, load the row read a cycle earlier
//  STREAM    | k_len cycles: read activation t, array running
//  DRAIN     | 2N cycles: array running with no new activations
//  DONE      | one-cycle done pulse, then back to IDLE
module pe_array_seq
    import pe_array_seq_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int K_MAX      = K_MAX_DEF,
    parameter int KW         = $clog2(K_MAX + 1),
    parameter int AW         = 8
)(
    input  logic          i_clk,
    input  logic          i_rst,
    pe_array_seq_if.slave sq
);

    localparam int N  = ARRAY_SIZE;
    localparam int CW = cnt_width(ARRAY_SIZE, K_MAX);
    localparam logic [N-1:0] W_ROW0 = N'(1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [KW-1:0] r_k_len;
    logic          w_stream;

    // state register, per-phase cycle counter (restarts on every state change) and k_len latch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k_len <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == ST_IDLE && sq.start) begin
                r_k_len <= sq.k_len;
            end
        end
    end

    // next-state decode; start is only looked at in IDLE, so DONE and busy phases ignore it
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sq.start) begin
                    w_next = (sq.k_len == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR:  w_next = ST_LOAD_W;
            ST_LOAD_W: if (r_cnt == CW'(N)) w_next = ST_STREAM;
            ST_STREAM: if (r_cnt == CW'(r_k_len) - CW'(1)) w_next = ST_DRAIN;
            ST_DRAIN:  if (r_cnt == CW'(2 * N - 1)) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // output decode from registered state and counter only; weight buffer has one cycle
    // of read latency, so the row read at count c is loaded at count c+1
    always_comb begin
        sq.busy        = (r_state != ST_IDLE);
        sq.done        = 1'b0;
        sq.z_weight    = 1'b0;
        sq.wgt_rd_en   = 1'b0;
        sq.wgt_rd_addr = '0;
        sq.weight_en   = '0;
        sq.act_rd_en   = 1'b0;
        sq.act_rd_addr = '0;
        sq.go          = 1'b0;
        case (r_state)
            ST_CLEAR: sq.z_weight = 1'b1;
            ST_LOAD_W: begin
                if (r_cnt < CW'(N)) begin
                    sq.wgt_rd_en   = 1'b1;
                    sq.wgt_rd_addr = AW'(r_cnt);
                end
                if (r_cnt != '0) begin
                    sq.weight_en = W_ROW0 << (r_cnt - CW'(1));
                end
            end
            ST_STREAM: begin
                sq.act_rd_en   = 1'b1;
                sq.act_rd_addr = AW'(r_cnt);
                sq.go          = 1'b1;
            end
            ST_DRAIN: sq.go   = 1'b1;
            ST_DONE:  sq.done = 1'b1;
            default: ;
        endcase
    end

    assign w_stream = (r_state == ST_STREAM);

    pe_array_seq_valid_delay #(
        .N (N)
    ) u_valid_delay (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flag      (w_stream),
        .o_col_valid (sq.col_valid)
    );

    // the phase counter is sized for K_MAX; longer jobs are not representable
    a_k_len_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_state == ST_IDLE && sq.start) |-> (sq.k_len <= KW'(K_MAX)));

endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq at N=4: a timeline model (outputs as a function of the
// cycle offset from the accepted start) checked every cycle, plus literal pins.
module tb_pe_array_seq;

    localparam int N    = 4;
    localparam int KMAX = 256;
    localparam int KW   = 9;
    localparam int AW   = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_array_seq_if #(.N(N), .KW(KW), .AW(AW)) sq_if ();

    pe_array_seq #(
        .ARRAY_SIZE (N),
        .K_MAX      (KMAX),
        .KW         (KW),
        .AW         (AW)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .sq    (sq_if)
    );

    int cyc      = 0;
    bit chk_en   = 1'b0;
    bit m_active = 1'b0;
    int m_s      = 0;
    int m_k      = 0;
    int n_chk    = 0;
    int n_err    = 0;
    int cnt_col [N];
    int cnt_z    = 0;

    function automatic int job_len(input int k);
        return (k == 0) ? 1 : k + 3 * N + 3;
    endfunction

    function automatic bit exp_busy(input int c);
        int d;
        d = c - m_s;
        return m_active && d >= 1 && d <= job_len(m_k);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // model: accept start only when the model says the sequencer is idle; reset aborts
    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (!exp_busy(cyc) && sq_if.start) begin
            m_active = 1'b1;
            m_s      = cyc;
            m_k      = int'(sq_if.k_len);
        end
        cyc    = cyc + 1;
        chk_en = 1'b1;
    end

    // compare every output every cycle against the job timeline
    always @(negedge clk) begin
        int d;
        int c;
        int tt;
        bit e_busy, e_done, e_z, e_wen, e_aen, e_go;
        int e_waddr, e_aaddr;
        bit [N-1:0] e_wgt, e_col;
        if (chk_en) begin
            d = cyc - m_s;
            e_busy = 0; e_done = 0; e_z = 0; e_wen = 0; e_aen = 0; e_go = 0;
            e_waddr = 0; e_aaddr = 0; e_wgt = '0; e_col = '0;
            if (m_active) begin
                e_busy = (d >= 1 && d <= job_len(m_k));
                if (m_k == 0) begin
                    e_done = (d == 1);
                end else begin
                    e_z = (d == 1);
                    if (d >= 2 && d <= N + 2) begin
                        c = d - 2;
                        if (c < N) begin
                            e_wen   = 1;
                            e_waddr = c;
                        end
                        if (c >= 1) e_wgt[c-1] = 1'b1;
                    end
                    if (d >= N + 3 && d < N + 3 + m_k) begin
                        e_aen   = 1;
                        e_aaddr = d - (N + 3);
                        e_go    = 1;
                    end
                    if (d >= N + 3 + m_k && d < 3 * N + 3 + m_k) e_go = 1;
                    e_done = (d == 3 * N + 3 + m_k);
                    for (int j = 0; j < N; j++) begin
                        tt = d - (2 * N + 4) - j;
                        if (tt >= 0 && tt < m_k) e_col[j] = 1'b1;
                    end
                end
            end
            check("busy",        int'(sq_if.busy),        int'(e_busy));
            check("done",        int'(sq_if.done),        int'(e_done));
            check("z_weight",    int'(sq_if.z_weight),    int'(e_z));
            check("wgt_rd_en",   int'(sq_if.wgt_rd_en),   int'(e_wen));
            check("wgt_rd_addr", int'(sq_if.wgt_rd_addr), e_waddr);
            check("weight_en",   int'(sq_if.weight_en),   int'(e_wgt));
            check("act_rd_en",   int'(sq_if.act_rd_en),   int'(e_aen));
            check("act_rd_addr", int'(sq_if.act_rd_addr), e_aaddr);
            check("go",          int'(sq_if.go),          int'(e_go));
            check("col_valid",   int'(sq_if.col_valid),   int'(e_col));
            for (int j = 0; j < N; j++) cnt_col[j] += int'(sq_if.col_valid[j]);
            cnt_z += int'(sq_if.z_weight);
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // called at a negedge: present start for exactly one sampling edge
    task automatic go_job(input int k, output int s);
        sq_if.start = 1'b1;
        sq_if.k_len = KW'(k);
        s = cyc;
        @(negedge clk);
        sq_if.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int s2;
        int base [N];
        int bz;
        int t_done;
        bit seen;

        for (int j = 0; j < N; j++) cnt_col[j] = 0;
        rst = 1'b1;
        sq_if.start = 1'b0;
        sq_if.k_len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",      int'(sq_if.busy),      0);
        check("rst_col_valid", int'(sq_if.col_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        // case 1: k_len=3
        go_job(3, s);
        wait_to(s + 1);  check("c1_z_weight@1",  int'(sq_if.z_weight),    1);
        wait_to(s + 3);  check("c1_weight_en@3", int'(sq_if.weight_en),   4'b0001);
        wait_to(s + 6);  check("c1_weight_en@6", int'(sq_if.weight_en),   4'b1000);
        wait_to(s + 7);  check("c1_act_en@7",    int'(sq_if.act_rd_en),   1);
                         check("c1_act_addr@7",  int'(sq_if.act_rd_addr), 0);
        wait_to(s + 9);  check("c1_act_addr@9",  int'(sq_if.act_rd_addr), 2);
        wait_to(s + 12); check("c1_col@12",      int'(sq_if.col_valid),   4'b0001);
        wait_to(s + 15); check("c1_col@15",      int'(sq_if.col_valid),   4'b1110);
        wait_to(s + 17); check("c1_col@17",      int'(sq_if.col_valid),   4'b1000);
        wait_to(s + 18); check("c1_done@18",     int'(sq_if.done),        1);
        wait_to(s + 19); check("c1_busy@19",     int'(sq_if.busy),        0);

        // case 2: k_len=0 goes straight to DONE
        @(negedge clk);
        go_job(0, s);
        check("c2_done@1", int'(sq_if.done), 1);
        check("c2_busy@1", int'(sq_if.busy), 1);
        wait_to(s + 2);
        check("c2_busy@2", int'(sq_if.busy), 0);

        // case 3: start held high through a job
        @(negedge clk);
        sq_if.start = 1'b1;
        sq_if.k_len = KW'(3);
        s = cyc;
        wait_to(s + 18); check("c3_done@18",  int'(sq_if.done),     1);
        wait_to(s + 19); check("c3_idle@19",  int'(sq_if.busy),     0);
        wait_to(s + 20); check("c3_clear@20", int'(sq_if.z_weight), 1);
        sq_if.start = 1'b0;
        s2 = s + 19;
        wait_to(s2 + 18); check("c3_done2", int'(sq_if.done), 1);
        wait_to(s2 + 19);

        // case 4: reset during STREAM aborts the job
        go_job(3, s);
        wait_to(s + 8);
        check("c4_act_addr@8", int'(sq_if.act_rd_addr), 1);
        rst = 1'b1;
        wait_to(s + 9);
        check("c4_busy@9",   int'(sq_if.busy),      0);
        check("c4_go@9",     int'(sq_if.go),        0);
        check("c4_act_en@9", int'(sq_if.act_rd_en), 0);
        check("c4_col@9",    int'(sq_if.col_valid), 0);
        rst = 1'b0;
        wait_to(s + 25);
        go_job(3, s);
        wait_to(s + 18); check("c4_done_rerun", int'(sq_if.done), 1);
        wait_to(s + 19);

        // case 5: k_len=K_MAX
        go_job(KMAX, s);
        wait_to(s + N + 3 + KMAX - 1);
        check("c5_act_addr_last", int'(sq_if.act_rd_addr), 255);
        seen   = 1'b0;
        t_done = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (sq_if.done) begin
                seen   = 1'b1;
                t_done = cyc - s;
            end else begin
                @(negedge clk);
            end
        end
        check("c5_job_len", t_done, 271);
        @(negedge clk);

        // case 6: back-to-back k_len=1 then k_len=5
        for (int j = 0; j < N; j++) base[j] = cnt_col[j];
        bz = cnt_z;
        go_job(1, s);
        wait_to(s + job_len(1) + 1);
        for (int j = 0; j < N; j++) check("c6_col_pulses_k1", cnt_col[j] - base[j], 1);
        check("c6_z_pulses_k1", cnt_z - bz, 1);
        for (int j = 0; j < N; j++) base[j] = cnt_col[j];
        bz = cnt_z;
        go_job(5, s);
        wait_to(s + job_len(5) + 1);
        for (int j = 0; j < N; j++) check("c6_col_pulses_k5", cnt_col[j] - base[j], 5);
        check("c6_z_pulses_k5", cnt_z - bz, 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
